// File: rtl/one_hot_ring_pkg.sv
// Shared definitions for the one-hot ring controller and its receive-side monitor.
package one_hot_ring_pkg;

    localparam int DEFAULT_RING_WIDTH = 3;
    localparam int MAX_RING_WIDTH     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_FAULT
    } ring_fsm_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_START,
        CLS_ONEHOT,
        CLS_ILLEGAL
    } sample_class_e;

    // Rotate the low `width` bits of value left by one; bits above width are returned as zero.
    function automatic logic [MAX_RING_WIDTH-1:0] rotate_left(
        input logic [MAX_RING_WIDTH-1:0] value,
        input int unsigned               width
    );
        logic [MAX_RING_WIDTH-1:0] mask;
        logic [MAX_RING_WIDTH-1:0] masked;
        mask   = (MAX_RING_WIDTH'(1'b1) << width) - 1'b1;
        masked = value & mask;
        return ((masked << 1) | (masked >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/one_hot_ring_decoder.sv
// Combinational decode of a ring state vector into zero / one-hot flags and the hot bit index.
module one_hot_ring_decoder
    import one_hot_ring_pkg::*;
#(
    parameter  int RING_WIDTH = DEFAULT_RING_WIDTH,
    localparam int IDX_WIDTH  = (RING_WIDTH > 1) ? $clog2(RING_WIDTH) : 1
) (
    input  logic [RING_WIDTH-1:0] ring_state,
    output logic                  is_zero,
    output logic                  is_onehot,
    output logic [IDX_WIDTH-1:0]  hot_idx
);

    assign is_zero   = (ring_state == '0);
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign is_onehot = !is_zero && ((ring_state & (ring_state - 1'b1)) == '0);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < RING_WIDTH; i++) begin
            if (ring_state[i]) begin
                hot_idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/one_hot_ring_monitor.sv
// Receive-side checker for the one-hot ring: tracks phase, counts laps, flags illegal patterns and moves.
module one_hot_ring_monitor
    import one_hot_ring_pkg::*;
#(
    parameter  int RING_WIDTH = DEFAULT_RING_WIDTH,
    parameter  int LAP_WIDTH  = 8,
    parameter  int ERR_WIDTH  = 8,
    localparam int IDX_WIDTH  = (RING_WIDTH > 1) ? $clog2(RING_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RING_WIDTH-1:0] ring_state,
    input  logic                  err_clear,
    output logic                  phase_valid,
    output logic [IDX_WIDTH-1:0]  phase_idx,
    output logic                  lap_pulse,
    output logic [LAP_WIDTH-1:0]  lap_count,
    output logic                  seq_error,
    output logic                  error_sticky,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RING_WIDTH - 1);

    ring_fsm_e                 state_q, state_d;
    sample_class_e             sample_class;
    logic                      is_zero, is_onehot;
    logic [IDX_WIDTH-1:0]      hot_idx;
    logic [IDX_WIDTH-1:0]      phase_idx_d;
    logic                      lap_d;
    logic                      err_event;
    logic [MAX_RING_WIDTH-1:0] expected_next;

    one_hot_ring_decoder #(
        .RING_WIDTH (RING_WIDTH)
    ) u_decoder (
        .ring_state (ring_state),
        .is_zero    (is_zero),
        .is_onehot  (is_onehot),
        .hot_idx    (hot_idx)
    );

    always_comb begin
        if (is_zero) begin
            sample_class = CLS_ZERO;
        end else if (!is_onehot) begin
            sample_class = CLS_ILLEGAL;
        end else if (hot_idx == '0) begin
            sample_class = CLS_START;
        end else begin
            sample_class = CLS_ONEHOT;
        end
    end

    // The only legal advance from phase p is the ring pattern for p rotated by one stage.
    assign expected_next = rotate_left(MAX_RING_WIDTH'(1'b1) << phase_idx, RING_WIDTH);

    always_comb begin
        state_d     = state_q;
        phase_idx_d = phase_idx;
        lap_d       = 1'b0;
        err_event   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_class == CLS_START) begin
                    state_d     = ST_TRACK;
                    phase_idx_d = '0;
                end else if (sample_class != CLS_ZERO) begin
                    state_d   = ST_FAULT;
                    err_event = 1'b1;
                end
            end
            ST_TRACK: begin
                if (sample_class == CLS_ZERO) begin
                    state_d = ST_IDLE;
                end else if (sample_class == CLS_START) begin
                    // Wrapping from the last stage is a lap; an early START is a re-initialize.
                    phase_idx_d = '0;
                    lap_d       = (phase_idx == LAST_IDX);
                end else if (ring_state == expected_next[RING_WIDTH-1:0]) begin
                    phase_idx_d = hot_idx;
                end else begin
                    state_d   = ST_FAULT;
                    err_event = 1'b1;
                end
            end
            ST_FAULT: begin
                if (sample_class == CLS_ZERO) begin
                    state_d = ST_IDLE;
                end else if (sample_class == CLS_START) begin
                    state_d     = ST_TRACK;
                    phase_idx_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_valid  <= 1'b0;
            phase_idx    <= '0;
            lap_pulse    <= 1'b0;
            lap_count    <= '0;
            seq_error    <= 1'b0;
            error_sticky <= 1'b0;
            err_count    <= '0;
        end else begin
            phase_valid <= (state_d == ST_TRACK);
            phase_idx   <= phase_idx_d;
            lap_pulse   <= lap_d;
            seq_error   <= err_event;
            if (lap_d) begin
                lap_count <= lap_count + 1'b1;
            end
            // A coincident error overrides err_clear so the new event is never lost.
            if (err_event) begin
                error_sticky <= 1'b1;
                if (err_clear) begin
                    err_count <= ERR_WIDTH'(1);
                end else if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end else if (err_clear) begin
                error_sticky <= 1'b0;
                err_count    <= '0;
            end
        end
    end

endmodule

// File: doc/one_hot_ring_monitor.md
# one_hot_ring_monitor

Receive-side checker for the one-hot ring state machine. It samples the ring's state vector every clock, decodes it to a binary phase index and counts completed laps. It also flags any illegal pattern or illegal transition. It sits beside the ring controller and feeds status and debug logic; it never drives the ring.

## Interface
- RING_WIDTH, 3, number of ring stages (≥2); the ring rotates left, bit0→bit1→…→bit[N-1]→bit0
- LAP_WIDTH, 8, width of lap counter
- ERR_WIDTH, 8, width of error counter
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; all state and outputs to reset values
- ring_state  in  RING_WIDTH  observed ring state vector
- err_clear  in  1  one-cycle request to clear error_sticky and err_count
- phase_valid  out  1  ring locked and tracking
- phase_idx  out  clog2(RING_WIDTH)  index of hot bit; valid only when phase_valid=1
- lap_pulse  out  1  one-cycle pulse per completed lap
- lap_count  out  LAP_WIDTH  completed laps, wraps modulo 2^LAP_WIDTH
- seq_error  out  1  one-cycle pulse on an illegal pattern or transition
- error_sticky  out  1  set by any error, held until err_clear
- err_count  out  ERR_WIDTH  errors seen, saturates at all-ones

## Operation
- Classification of each sample: ZERO (all 0), START (only bit0 set), ONEHOT(k) (only bit k set), ILLEGAL (two or more bits set).
- FSM states: IDLE, TRACK, FAULT. Reset state is IDLE.
- IDLE:
  - ZERO: stay.
  - START: go to TRACK with phase_idx=0.
  - ONEHOT(k) with k≠0, or ILLEGAL: error, go to FAULT.
- TRACK (prev = last hot index p):
  - ONEHOT((p+1) mod N): legal rotation; phase_idx updated.
  - If p=N-1 and the sample is START: counts as a lap (lap_pulse=1, lap_count+1).
  - START when p≠N-1: legal re-initialize; phase_idx=0, no lap.
  - ZERO: legal flush; go to IDLE, phase_valid=0.
  - Any other value, including a repeat of p (hold) or ILLEGAL: error, go to FAULT.
- FAULT:
  - phase_valid=0.
  - ZERO: go to IDLE.
  - START: go directly to TRACK with phase_idx=0.
  - Anything else: stay in FAULT with no further error pulses; only the entering event is counted.
- Error event: seq_error=1 for one cycle, error_sticky set, err_count+1 (saturating).
- err_clear: error_sticky→0 and err_count→0. If an error event occurs in the same cycle, the error wins: error_sticky=1, err_count=1.
- lap_count is not cleared by flush, fault or err_clear; only reset clears it.

## Timing
- All outputs are registered. The response to the ring_state sampled at edge n appears after edge n, stable through cycle n+1. Latency is 1 cycle.
- Reset values: phase_valid=0, phase_idx=0, lap_pulse=0, lap_count=0, seq_error=0, error_sticky=0, err_count=0, FSM=IDLE.
- Reset has priority over every input, including err_clear.
- The ring advances every cycle. A hold of one cycle in TRACK is an error.
- lap_pulse and seq_error are mutually exclusive: an erroneous sample never counts a lap.
- lap_count wraps from 2^LAP_WIDTH-1 to 0 without error.
- err_count saturates at 2^ERR_WIDTH-1; further errors still pulse seq_error.

## Structure
- Package one_hot_ring_pkg holds:
  - the FSM state enum (IDLE/TRACK/FAULT),
  - the sample classification enum,
  - a rotate-left function shared with the ring controller,
  - the default RING_WIDTH constant.
- Sub-module one_hot_ring_decoder: purely combinational. Takes ring_state and produces is_zero, is_onehot and hot_idx. It is instantiated once.
- The top level holds the FSM, the previous-index register, both counters and the sticky logic.

## Test plan
- Reset, then ring_state 000 for 5 cycles → phase_valid=0, all outputs 0.
- Sequence 000, 001, 010, 100, 001, 010 → phase_valid=1 from the 2nd response; phase_idx 0,1,2,0,1; one lap_pulse on 100→001; lap_count=1.
- In TRACK at 010, drive 011 → seq_error pulse, error_sticky=1, err_count=1, phase_valid=0. Then 011 for 3 more cycles → no further pulses. Then 001 → TRACK, phase_idx=0.
- In TRACK at 010, drive 010 again (hold) → error. Assert err_clear in the same cycle as the next error → error_sticky=1, err_count=1.
- In TRACK at 010, drive 001 → no error, no lap, phase_idx=0. Then drive 000 → IDLE, phase_valid=0, lap_count unchanged.
- LAP_WIDTH=2: run 5 full laps → lap_count sequence 1,2,3,0,1. ERR_WIDTH=2: force 5 errors → err_count stops at 3, seq_error pulses 5 times.
